// File: rtl/area_scan_accumulator_if.sv
// ---------------------------------------------------------------------------
// area_scan_accumulator_if
// Bundles the sample stream, scan control and result handshake of the scan
// accumulator.
//   scan_start : pulse that begins (or restarts) a scan
//   area       : unsigned area sample, qualified by area_rdy
//   area_rdy   : area is valid this cycle (no backpressure upstream)
//   sum_data   : scan total (saturating)
//   sum_ovf    : total saturated during the scan
//   sum_valid  : result valid, held until sum_ready
//   sum_ready  : consumer accepts the result
//   busy       : scan in progress
//   drop_err   : sticky, a sample was discarded
// Modports: master drives stimulus/accepts results, slave is the accumulator.
// ---------------------------------------------------------------------------
interface area_scan_accumulator_if #(
   parameter int AREA_W = 26,
   parameter int SUM_W  = 40
);
   logic              scan_start;
   logic [AREA_W-1:0] area;
   logic              area_rdy;
   logic [SUM_W-1:0]  sum_data;
   logic              sum_ovf;
   logic              sum_valid;
   logic              sum_ready;
   logic              busy;
   logic              drop_err;

   modport master (
      output scan_start, area, area_rdy, sum_ready,
      input  sum_data, sum_ovf, sum_valid, busy, drop_err
   );

   modport slave (
      input  scan_start, area, area_rdy, sum_ready,
      output sum_data, sum_ovf, sum_valid, busy, drop_err
   );
endinterface

// File: rtl/area_scan_accumulator.sv
// ---------------------------------------------------------------------------
// area_scan_accumulator
// Sums SCAN_LEN unsigned area samples into a saturating SUM_W-bit total and
// presents the result on a valid/ready port.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : area_scan_accumulator_if.slave (samples, control, result, flags)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module area_scan_accumulator #(
   parameter int AREA_W   = 26,
   parameter int SUM_W    = 40,
   parameter int SCAN_LEN = 360
) (
   input  logic                     clk,
   input  logic                     rst,
   area_scan_accumulator_if.slave   bus
);

   localparam int CNT_W = $clog2(SCAN_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_LEN - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SUM_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [SUM_W-1:0]   sum_data_q, sum_data_d;
   logic               sum_ovf_q, sum_ovf_d;
   logic               sum_valid_q, sum_valid_d;
   logic               busy_q, busy_d;
   logic               drop_q, drop_d;

   logic [SUM_W:0]     add_s;    // {carry, saturated sum}
   logic [SUM_W-1:0]   first_s;  // sample zero-extended, first sample of a scan

   // Saturating add: on carry out the result clamps to all-ones and the
   // carry bit is returned as the overflow indication.
   function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                              input logic [AREA_W-1:0] b);
      logic [SUM_W:0] raw;
      raw = {1'b0, a} + {{(SUM_W + 1 - AREA_W){1'b0}}, b};
      if (raw[SUM_W]) begin
         sat_add = {1'b1, {SUM_W{1'b1}}};
      end else begin
         sat_add = raw;
      end
   endfunction

   // Next-state, datapath and result logic.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      sum_data_d  = sum_data_q;
      sum_ovf_d   = sum_ovf_q;
      sum_valid_d = sum_valid_q;
      drop_d      = drop_q;
      add_s       = sat_add(acc_q, bus.area);
      first_s     = {{(SUM_W - AREA_W){1'b0}}, bus.area};

      case (state_q)
         IDLE: begin
            if (bus.scan_start) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ACCUM;
            end else begin
               state_d = IDLE;
            end
            // Nothing is collecting in IDLE, so any sample is lost.
            if (bus.area_rdy) begin
               drop_d = 1'b1;
            end else begin
               drop_d = drop_q;
            end
         end

         ACCUM: begin
            if (bus.scan_start) begin
               // Abort: restart, a coincident sample opens the new scan.
               ovf_d = 1'b0;
               if (bus.area_rdy) begin
                  acc_d = first_s;
                  cnt_d = ONE_CNT;
               end else begin
                  acc_d = '0;
                  cnt_d = '0;
               end
            end else if (bus.area_rdy) begin
               acc_d = add_s[SUM_W-1:0];
               ovf_d = ovf_q | add_s[SUM_W];
               if (cnt_q == LAST_CNT) begin
                  // Last sample: capture the total including this sample.
                  // cnt is left alone so it never wraps.
                  sum_data_d  = add_s[SUM_W-1:0];
                  sum_ovf_d   = ovf_q | add_s[SUM_W];
                  sum_valid_d = 1'b1;
                  state_d     = HOLD;
               end else begin
                  cnt_d = cnt_q + ONE_CNT;
               end
            end else begin
               state_d = ACCUM;
            end
         end

         HOLD: begin
            if (bus.sum_ready) begin
               sum_valid_d = 1'b0;
               if (bus.scan_start) begin
                  // Handshake plus start: zero-gap restart, sample counts.
                  ovf_d   = 1'b0;
                  state_d = ACCUM;
                  if (bus.area_rdy) begin
                     acc_d = first_s;
                     cnt_d = ONE_CNT;
                  end else begin
                     acc_d = '0;
                     cnt_d = '0;
                  end
               end else begin
                  state_d = IDLE;
                  if (bus.area_rdy) begin
                     drop_d = 1'b1;
                  end else begin
                     drop_d = drop_q;
                  end
               end
            end else begin
               // Result is held; scan_start is ignored, samples are lost.
               if (bus.area_rdy) begin
                  drop_d = 1'b1;
               end else begin
                  drop_d = drop_q;
               end
            end
         end

         default: begin
            state_d     = IDLE;
            sum_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d == ACCUM);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         sum_data_q  <= '0;
         sum_ovf_q   <= 1'b0;
         sum_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         sum_data_q  <= sum_data_d;
         sum_ovf_q   <= sum_ovf_d;
         sum_valid_q <= sum_valid_d;
         busy_q      <= busy_d;
         drop_q      <= drop_d;
      end
   end

   assign bus.sum_data  = sum_data_q;
   assign bus.sum_ovf   = sum_ovf_q;
   assign bus.sum_valid = sum_valid_q;
   assign bus.busy      = busy_q;
   assign bus.drop_err  = drop_q;

endmodule

// File: tb/tb_area_scan_accumulator.sv
// ---------------------------------------------------------------------------
// tb_area_scan_accumulator
// Drives two accumulators (SUM_W=28 and SUM_W=27, SCAN_LEN=4) with the same
// stimulus. Inputs change just after the falling edge; outputs are read on
// the falling edge following the rising edge that consumed them.
// ---------------------------------------------------------------------------
module tb_area_scan_accumulator;
   localparam int AW = 26;
   localparam int SL = 4;
   localparam longint unsigned AMAX = 64'h3FFFFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          scan_start = 1'b0;
   logic          area_rdy = 1'b0;
   logic          sum_ready = 1'b0;
   logic [AW-1:0] area = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   area_scan_accumulator_if #(.AREA_W(AW), .SUM_W(28)) bw ();
   area_scan_accumulator_if #(.AREA_W(AW), .SUM_W(27)) bn ();

   assign bw.scan_start = scan_start;
   assign bw.area       = area;
   assign bw.area_rdy   = area_rdy;
   assign bw.sum_ready  = sum_ready;
   assign bn.scan_start = scan_start;
   assign bn.area       = area;
   assign bn.area_rdy   = area_rdy;
   assign bn.sum_ready  = sum_ready;

   area_scan_accumulator #(.AREA_W(AW), .SUM_W(28), .SCAN_LEN(SL)) dut_w (
      .clk(clk), .rst(rst), .bus(bw));
   area_scan_accumulator #(.AREA_W(AW), .SUM_W(27), .SCAN_LEN(SL)) dut_n (
      .clk(clk), .rst(rst), .bus(bn));

   // Reference: unbounded sum, clamped to the result width.
   function automatic void model(input longint unsigned s[$], input int w,
                                 output longint unsigned d, output bit o);
      longint unsigned tot, mx;
      tot = 0;
      mx  = (64'd1 << w) - 64'd1;
      foreach (s[i]) tot += s[i];
      if (tot > mx) begin d = mx; o = 1'b1; end
      else begin d = tot; o = 1'b0; end
   endfunction

   // One clock: apply inputs, advance to the next falling edge, then idle.
   task automatic cyc(input bit ss, input bit rdy, input longint unsigned a);
      scan_start = ss;
      area_rdy   = rdy;
      area       = a[AW-1:0];
      @(negedge clk);
      scan_start = 1'b0;
      area_rdy   = 1'b0;
   endtask

   task automatic scan4(input longint unsigned a, input longint unsigned b,
                        input longint unsigned c, input longint unsigned d);
      cyc(1'b1, 1'b0, 0);
      cyc(1'b0, 1'b1, a);
      cyc(1'b0, 1'b1, b);
      cyc(1'b0, 1'b1, c);
      cyc(1'b0, 1'b1, d);
   endtask

   task automatic test_reset();
      #1;
      checks++; if (bw.sum_valid !== 1'b0 || bn.sum_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b want 0", bw.sum_valid, bn.sum_valid); end
      checks++; if (bw.sum_data !== 28'd0 || bn.sum_data !== 27'd0) begin errors++; $display("FAIL reset_data: got %0d/%0d want 0", bw.sum_data, bn.sum_data); end
      checks++; if ({bw.busy, bw.drop_err, bw.sum_ovf, bn.busy, bn.drop_err, bn.sum_ovf} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b%b%b want 000", bw.busy, bw.drop_err, bw.sum_ovf); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      sum_ready = 1'b1;
      cyc(1'b1, 1'b0, 0);
      checks++; if (bw.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", bw.busy); end
      cyc(1'b0, 1'b1, 10);
      cyc(1'b0, 1'b1, 20);
      cyc(1'b0, 1'b1, 30);
      checks++; if (bw.sum_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bw.sum_valid); end
      cyc(1'b0, 1'b1, 40);
      checks++; if (bw.sum_valid !== 1'b1 || bn.sum_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b/%b want 1", bw.sum_valid, bn.sum_valid); end
      checks++; if (bw.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", bw.busy); end
      checks++; if (bw.sum_data !== 28'd100 || bn.sum_data !== 27'd100) begin errors++; $display("FAIL basic_sum: got %0d/%0d want 100", bw.sum_data, bn.sum_data); end
      checks++; if (bw.sum_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", bw.sum_ovf); end
      cyc(1'b0, 1'b0, 0);
      checks++; if (bw.sum_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall: got %b want 0", bw.sum_valid); end
   endtask

   task automatic test_gapped();
      sum_ready = 1'b0;
      cyc(1'b1, 1'b0, 0);
      cyc(1'b0, 1'b1, 10); repeat (1) cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 20); repeat (3) cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 30); repeat (2) cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 40);
      for (int i = 0; i < 5; i++) begin
         checks++; if (bw.sum_valid !== 1'b1 || bw.sum_data !== 28'd100) begin errors++; $display("FAIL gapped_hold%0d: got v=%b d=%0d want v=1 d=100", i, bw.sum_valid, bw.sum_data); end
         cyc(1'b0, 1'b0, 0);
      end
      sum_ready = 1'b1;
      cyc(1'b0, 1'b0, 0);
      checks++; if (bw.sum_valid !== 1'b0) begin errors++; $display("FAIL gapped_valid_fall: got %b want 0", bw.sum_valid); end
   endtask

   task automatic test_saturation();
      sum_ready = 1'b1;
      scan4(AMAX, AMAX, AMAX, AMAX);
      checks++; if (bn.sum_data !== 27'h7FFFFFF || bn.sum_ovf !== 1'b1) begin errors++; $display("FAIL sat_narrow: got %h ovf=%b want 7ffffff ovf=1", bn.sum_data, bn.sum_ovf); end
      checks++; if (bw.sum_data !== 28'hFFFFFFC || bw.sum_ovf !== 1'b0) begin errors++; $display("FAIL sat_wide: got %h ovf=%b want ffffffc ovf=0", bw.sum_data, bw.sum_ovf); end
      cyc(1'b0, 1'b0, 0);
      scan4(1, 1, 1, 1);
      checks++; if (bn.sum_data !== 27'd4 || bn.sum_ovf !== 1'b0) begin errors++; $display("FAIL sat_recover: got %0d ovf=%b want 4 ovf=0", bn.sum_data, bn.sum_ovf); end
      cyc(1'b0, 1'b0, 0);
   endtask

   task automatic test_abort();
      sum_ready = 1'b1;
      cyc(1'b1, 1'b0, 0);
      cyc(1'b0, 1'b1, 5);
      cyc(1'b0, 1'b1, 6);
      cyc(1'b1, 1'b1, 7);
      checks++; if (bw.busy !== 1'b1 || bw.sum_valid !== 1'b0) begin errors++; $display("FAIL abort_state: got busy=%b v=%b want 1/0", bw.busy, bw.sum_valid); end
      cyc(1'b0, 1'b1, 8);
      cyc(1'b0, 1'b1, 9);
      cyc(1'b0, 1'b1, 10);
      checks++; if (bw.sum_valid !== 1'b1 || bw.sum_data !== 28'd34) begin errors++; $display("FAIL abort_sum: got v=%b d=%0d want v=1 d=34", bw.sum_valid, bw.sum_data); end
      checks++; if (bw.drop_err !== 1'b0) begin errors++; $display("FAIL abort_drop: got %b want 0", bw.drop_err); end
      cyc(1'b0, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      sum_ready = 1'b1;
      scan4(100, 200, 300, 400);
      checks++; if (bw.sum_valid !== 1'b1 || bw.sum_data !== 28'd1000) begin errors++; $display("FAIL b2b_first: got v=%b d=%0d want v=1 d=1000", bw.sum_valid, bw.sum_data); end
      cyc(1'b1, 1'b1, 1);
      checks++; if (bw.sum_valid !== 1'b0 || bw.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got v=%b busy=%b want 0/1", bw.sum_valid, bw.busy); end
      cyc(1'b0, 1'b1, 2);
      cyc(1'b0, 1'b1, 3);
      cyc(1'b0, 1'b1, 4);
      checks++; if (bw.sum_valid !== 1'b1 || bw.sum_data !== 28'd10) begin errors++; $display("FAIL b2b_second: got v=%b d=%0d want v=1 d=10", bw.sum_valid, bw.sum_data); end
      checks++; if (bw.drop_err !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b want 0", bw.drop_err); end
      cyc(1'b0, 1'b0, 0);
   endtask

   task automatic test_random();
      longint unsigned q[$];
      longint unsigned v, ew, en;
      bit ow, on;
      int k, bp, aborts;
      for (int s = 0; s < 24; s++) begin
         bp = $urandom_range(0, 3);
         sum_ready = (bp == 0);
         q.delete();
         cyc(1'b1, 1'b0, 0);
         k = 0;
         aborts = 0;
         while (k < SL) begin
            repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 0);
            case ($urandom_range(0, 3))
               0:       v = AMAX;
               1:       v = $urandom_range(0, 100);
               default: v = longint'($urandom) & AMAX;
            endcase
            if (k > 0 && aborts < 2 && $urandom_range(0, 7) == 0) begin
               aborts++;
               q.delete();
               q.push_back(v);
               cyc(1'b1, 1'b1, v);
               k = 1;
            end else begin
               q.push_back(v);
               cyc(1'b0, 1'b1, v);
               k++;
            end
         end
         model(q, 28, ew, ow);
         model(q, 27, en, on);
         checks++; if (bw.sum_valid !== 1'b1 || bw.sum_data !== ew[27:0] || bw.sum_ovf !== ow) begin errors++; $display("FAIL rand%0d_wide: got v=%b d=%0d o=%b want v=1 d=%0d o=%b", s, bw.sum_valid, bw.sum_data, bw.sum_ovf, ew, ow); end
         checks++; if (bn.sum_valid !== 1'b1 || bn.sum_data !== en[26:0] || bn.sum_ovf !== on) begin errors++; $display("FAIL rand%0d_narrow: got v=%b d=%0d o=%b want v=1 d=%0d o=%b", s, bn.sum_valid, bn.sum_data, bn.sum_ovf, en, on); end
         for (int i = 0; i < bp; i++) begin
            cyc(1'b0, 1'b0, 0);
            checks++; if (bn.sum_valid !== 1'b1 || bn.sum_data !== en[26:0] || bn.sum_ovf !== on) begin errors++; $display("FAIL rand%0d_stable: got v=%b d=%0d want v=1 d=%0d", s, bn.sum_valid, bn.sum_data, en); end
         end
         sum_ready = 1'b1;
         cyc(1'b0, 1'b0, 0);
         checks++; if (bw.sum_valid !== 1'b0 || bw.drop_err !== 1'b0) begin errors++; $display("FAIL rand%0d_end: got v=%b drop=%b want 0/0", s, bw.sum_valid, bw.drop_err); end
      end
   endtask

   task automatic test_drops();
      sum_ready = 1'b1;
      cyc(1'b0, 1'b1, 123);
      checks++; if (bw.drop_err !== 1'b1 || bn.drop_err !== 1'b1) begin errors++; $display("FAIL drop_idle: got %b/%b want 1", bw.drop_err, bn.drop_err); end
      sum_ready = 1'b0;
      scan4(1, 2, 3, 4);
      checks++; if (bw.sum_valid !== 1'b1 || bw.sum_data !== 28'd10) begin errors++; $display("FAIL drop_scan: got v=%b d=%0d want v=1 d=10", bw.sum_valid, bw.sum_data); end
      cyc(1'b1, 1'b0, 0);
      checks++; if (bw.sum_valid !== 1'b1 || bw.sum_data !== 28'd10 || bw.busy !== 1'b0) begin errors++; $display("FAIL drop_hold_start: got v=%b d=%0d busy=%b want 1/10/0", bw.sum_valid, bw.sum_data, bw.busy); end
      cyc(1'b0, 1'b1, 55);
      checks++; if (bw.sum_data !== 28'd10) begin errors++; $display("FAIL drop_hold_sample: got %0d want 10", bw.sum_data); end
      sum_ready = 1'b1;
      cyc(1'b0, 1'b0, 0);
      scan4(2, 2, 2, 2);
      checks++; if (bw.sum_data !== 28'd8 || bw.drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky: got d=%0d drop=%b want 8/1", bw.sum_data, bw.drop_err); end
      cyc(1'b0, 1'b0, 0);
   endtask

   task automatic test_async_reset();
      sum_ready = 1'b1;
      cyc(1'b1, 1'b0, 0);
      cyc(1'b0, 1'b1, 7);
      cyc(1'b0, 1'b1, 8);
      #2 rst = 1'b1;
      #1;
      checks++; if ({bw.busy, bw.drop_err, bw.sum_valid, bw.sum_ovf} !== 4'b0 || bw.sum_data !== 28'd0) begin errors++; $display("FAIL async_rst: got busy=%b drop=%b v=%b d=%0d want all 0", bw.busy, bw.drop_err, bw.sum_valid, bw.sum_data); end
      @(negedge clk);
      rst = 1'b0;
      scan4(1, 2, 3, 4);
      checks++; if (bw.sum_valid !== 1'b1 || bw.sum_data !== 28'd10 || bn.sum_data !== 27'd10) begin errors++; $display("FAIL async_fresh: got v=%b d=%0d/%0d want v=1 d=10", bw.sum_valid, bw.sum_data, bn.sum_data); end
      cyc(1'b0, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_saturation();
      test_abort();
      test_back_to_back();
      test_random();
      test_drops();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
